// File: rtl/taillight_decoder.sv
// Receive-side decoder for the turn-signal tail-light FSM: recognises left, right and
// hazard lamp sequences, counts completions and latches a sticky error on illegal patterns.
//
//  state   | meaning
//  --------+--------------------------------------------
//  S_IDLE  | all lamps off, waiting for a sequence start
//  S_L1    | left 001 seen
//  S_L2    | left 011 seen
//  S_L3    | left 111 seen, expecting all-off
//  S_R1    | right 001 seen
//  S_R2    | right 011 seen
//  S_R3    | right 111 seen, expecting all-off
//  S_HAZ   | all six lamps on, expecting all-off
//  S_ERR   | illegal pattern seen, waiting for all-off
module taillight_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [2:0]       left,
    input  logic [2:0]       right,
    output logic [1:0]       mode,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] seq_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_L1,
        S_L2,
        S_L3,
        S_R1,
        S_R2,
        S_R3,
        S_HAZ,
        S_ERR
    } state_t;

    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_RIGHT  = 2'b10;
    localparam logic [1:0] MODE_HAZARD = 2'b11;

    state_t           r_state;
    state_t           w_next;
    logic             w_complete;
    logic [1:0]       w_kind;
    logic             w_off;
    logic [1:0]       r_mode;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    assign w_off = (left == 3'b000) && (right == 3'b000);

    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        w_kind     = 2'b00;
        if (sample_en) begin
            case (r_state)
                S_IDLE: begin
                    if (w_off)                                   w_next = S_IDLE;
                    else if (left == 3'b001 && right == 3'b000)  w_next = S_L1;
                    else if (left == 3'b000 && right == 3'b001)  w_next = S_R1;
                    else if (left == 3'b111 && right == 3'b111)  w_next = S_HAZ;
                    else                                         w_next = S_ERR;
                end
                S_L1: w_next = (left == 3'b011 && right == 3'b000) ? S_L2 : S_ERR;
                S_L2: w_next = (left == 3'b111 && right == 3'b000) ? S_L3 : S_ERR;
                S_R1: w_next = (left == 3'b000 && right == 3'b011) ? S_R2 : S_ERR;
                S_R2: w_next = (left == 3'b000 && right == 3'b111) ? S_R3 : S_ERR;
                S_L3, S_R3, S_HAZ: begin
                    if (w_off) begin
                        w_next     = S_IDLE;
                        w_complete = 1'b1;
                        w_kind     = (r_state == S_L3) ? MODE_LEFT :
                                     (r_state == S_R3) ? MODE_RIGHT : MODE_HAZARD;
                    end else begin
                        w_next = S_ERR;
                    end
                end
                S_ERR:   w_next = w_off ? S_IDLE : S_ERR;
                default: w_next = S_ERR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_mode  <= 2'b00;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_complete;
            if (w_complete) begin
                r_mode <= w_kind;
                if (r_cnt != {CNT_W{1'b1}})
                    r_cnt <= r_cnt + CNT_W'(1);
            end
            // err is sticky: set on any sampled edge that lands in ERR, cleared only by reset
            if (sample_en && w_next == S_ERR)
                r_err <= 1'b1;
        end
    end

    assign mode      = r_mode;
    assign done      = r_done;
    assign err       = r_err;
    assign seq_count = r_cnt;

endmodule

// File: tb/tb_taillight_decoder.sv
// Bench for taillight_decoder: two instances (CNT_W=8 and CNT_W=2) share stimulus and are
// compared every cycle against a sequence-matching reference model.
module tb_taillight_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_en = 1'b0;
    logic [2:0] left = 3'b000;
    logic [2:0] right = 3'b000;

    logic [1:0] mode_a, mode_b;
    logic       done_a, done_b, err_a, err_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    taillight_decoder #(.CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .sample_en(sample_en), .left(left), .right(right),
        .mode(mode_a), .done(done_a), .err(err_a), .seq_count(cnt_a)
    );

    taillight_decoder #(.CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .sample_en(sample_en), .left(left), .right(right),
        .mode(mode_b), .done(done_b), .err(err_b), .seq_count(cnt_b)
    );

    // Reference model: legal sequences as pattern lists, matched against a history buffer.
    logic [5:0] tbl [1:3][0:2];
    int         tbl_len [1:3];
    logic [5:0] hist [$];
    bit         m_inerr;
    logic [1:0] m_mode;
    bit         m_done, m_err;
    int         m_cnt_a, m_cnt_b;

    function automatic void classify(output bit prefix_ok, output int full_kind);
        prefix_ok = 0;
        full_kind = 0;
        for (int k = 1; k <= 3; k++) begin
            bit ok;
            ok = (hist.size() <= tbl_len[k]);
            for (int i = 0; i < hist.size() && ok; i++)
                if (hist[i] != tbl[k][i]) ok = 0;
            if (ok) begin
                prefix_ok = 1;
                if (hist.size() == tbl_len[k]) full_kind = k;
            end
        end
    endfunction

    task automatic model_step(input bit rst_n, input bit se, input logic [5:0] p);
        bit pok;
        int fk;
        m_done = 0;
        if (!rst_n) begin
            hist.delete(); m_inerr = 0; m_mode = 0; m_err = 0; m_cnt_a = 0; m_cnt_b = 0;
            return;
        end
        if (!se) return;
        if (m_inerr) begin
            if (p == 0) m_inerr = 0;
            return;
        end
        if (p == 0) begin
            if (hist.size() == 0) return;
            classify(pok, fk);
            if (fk != 0) begin
                m_mode = 2'(fk);
                m_done = 1;
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_b < 3) m_cnt_b++;
                hist.delete();
            end else begin
                m_err = 1; m_inerr = 1; hist.delete();
            end
            return;
        end
        hist.push_back(p);
        classify(pok, fk);
        if (!pok) begin
            m_err = 1; m_inerr = 1; hist.delete();
        end
    endtask

    function automatic logic [17:0] exp_vec();
        return {m_mode, m_done, m_err, 8'(m_cnt_a), m_mode, m_done, m_err, 2'(m_cnt_b)};
    endfunction

    function automatic logic [17:0] got_vec();
        return {mode_a, done_a, err_a, cnt_a, mode_b, done_b, err_b, cnt_b};
    endfunction

    task automatic cycle(input bit rst_n, input bit se, input logic [2:0] l, input logic [2:0] r);
        reset = rst_n; sample_en = se; left = l; right = r;
        @(posedge clk);
        model_step(rst_n, se, {l, r});
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 3'b111, 3'b000);
            n_cmp++;
            if (got_vec() !== 18'h0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %h want %h", i, got_vec(), 18'h0);
            end
        end
    endtask

    task automatic test_left();
        logic [2:0] ls [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
        int dones = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, ls[i], 3'b000);
            dones += int'(done_a);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL left step %0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        cycle(1, 0, 3'b000, 3'b000);
        dones += int'(done_a);
        n_cmp++;
        if (dones != 1 || mode_a !== 2'b01 || cnt_a !== 8'd1 || err_a !== 1'b0) begin
            n_bad++;
            $display("FAIL left summary: dones=%0d mode=%b cnt=%0d err=%b want 1/01/1/0",
                     dones, mode_a, cnt_a, err_a);
        end
    endtask

    task automatic test_right_hazard();
        logic [5:0] ps [6] = '{6'o01, 6'o03, 6'o07, 6'o00, 6'o77, 6'o00};
        int dones = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, ps[i][5:3], ps[i][2:0]);
            dones += int'(done_a);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL right_hazard step %0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (dones != 2 || mode_a !== 2'b11) begin
            n_bad++;
            $display("FAIL right_hazard dones: got %0d mode %b want 2 11", dones, mode_a);
        end
    endtask

    task automatic test_gaps();
        logic [2:0] ls [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
        int dones = 0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 3; g++) begin
                cycle(1, 0, 3'b101, 3'b110);
                dones += int'(done_a);
            end
            cycle(1, 1, ls[i], 3'b000);
            dones += int'(done_a);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL gaps step %0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (dones != 1 || mode_a !== 2'b01 || err_a !== 1'b0) begin
            n_bad++;
            $display("FAIL gaps summary: dones=%0d mode=%b err=%b want 1/01/0", dones, mode_a, err_a);
        end
    endtask

    task automatic test_error();
        logic [5:0] ps [7] = '{6'o30, 6'o70, 6'o00, 6'o10, 6'o30, 6'o70, 6'o00};
        for (int i = 0; i < 7; i++) begin
            cycle(1, 1, ps[i][5:3], ps[i][2:0]);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL error step %0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (err_a !== 1'b1 || mode_a !== 2'b01 || done_a !== 1'b1) begin
            n_bad++;
            $display("FAIL error summary: err=%b mode=%b done=%b want 1/01/1", err_a, mode_a, done_a);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 1, 3'b001, 3'b000);
        cycle(1, 1, 3'b011, 3'b000);
        cycle(0, 0, 3'b000, 3'b000);
        n_cmp++;
        if (got_vec() !== 18'h0) begin
            n_bad++;
            $display("FAIL reset_mid cleared: got %h want %h", got_vec(), 18'h0);
        end
        cycle(1, 1, 3'b111, 3'b000);
        n_cmp++;
        if (got_vec() !== exp_vec() || err_a !== 1'b1 || done_a !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid err: got %h want %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_saturate();
        int dones = 0;
        cycle(0, 0, 3'b000, 3'b000);
        for (int s = 0; s < 5; s++) begin
            cycle(1, 1, 3'b111, 3'b111);
            cycle(1, 1, 3'b000, 3'b000);
            dones += int'(done_b);
            n_cmp++;
            if (got_vec() !== exp_vec() || cnt_b !== 2'((s + 1 > 3) ? 3 : s + 1)) begin
                n_bad++;
                $display("FAIL saturate seq %0d: got %h want %h", s, got_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (dones != 5) begin
            n_bad++;
            $display("FAIL saturate dones: got %0d want 5", dones);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 80; s++) begin
            int k;
            k = $urandom_range(1, 3);
            for (int i = 0; i <= tbl_len[k]; i++) begin
                logic [5:0] p;
                p = (i == tbl_len[k]) ? 6'o00 : tbl[k][i];
                if ($urandom_range(0, 9) == 0) p = 6'($urandom);
                while ($urandom_range(0, 3) == 0) begin
                    cycle(1, 0, 3'($urandom), 3'($urandom));
                    n_cmp++;
                    if (got_vec() !== exp_vec()) begin
                        n_bad++;
                        $display("FAIL random gap seq %0d: got %h want %h", s, got_vec(), exp_vec());
                    end
                end
                cycle(($urandom_range(0, 60) != 0), 1, p[5:3], p[2:0]);
                n_cmp++;
                if (got_vec() !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL random seq %0d pat %o: got %h want %h", s, p, got_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        tbl[1] = '{6'o10, 6'o30, 6'o70};
        tbl[2] = '{6'o01, 6'o03, 6'o07};
        tbl[3] = '{6'o77, 6'o00, 6'o00};
        tbl_len[1] = 3; tbl_len[2] = 3; tbl_len[3] = 1;
        m_inerr = 0; m_mode = 0; m_done = 0; m_err = 0; m_cnt_a = 0; m_cnt_b = 0;

        test_reset();
        test_left();
        test_right_hazard();
        test_gaps();
        test_error();
        test_reset_mid();
        test_saturate();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/taillight_decoder.md
Name: taillight_decoder

Overview:
- Receive-side monitor for the turn-signal tail-light FSM: observes the six lamp outputs and decodes which signalling sequence is being driven (left, right, hazard).
- Reports each completed sequence, counts completions, and flags any illegal lamp pattern or ordering.
- Sits beside the tail-light FSM in the lab top level and in its benches, as the decoder for that FSM's lamp encoding.

Parameters:
- CNT_W, 8, width of the completed-sequence counter (saturating).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-low reset; sampled on the rising clk edge.
- sample_en  input  1  high when lamp inputs hold a new pattern; lamps are only checked on cycles with sample_en=1.
- left  input  3  left lamps; bit0=LA (inner), bit1=LB, bit2=LC (outer).
- right  input  3  right lamps; bit0=RA (inner), bit1=RB, bit2=RC (outer).
- mode  output  2  last completed sequence: 00 none, 01 left, 10 right, 11 hazard.
- done  output  1  one-cycle pulse when a sequence completes.
- err  output  1  sticky error flag.
- seq_count  output  CNT_W  number of completed sequences, saturating.

Behaviour:
- All outputs are registered.
- reset=0 at a rising edge:
  - state=IDLE; mode=00, done=0, err=0, seq_count=0.
  - Reset has priority over sample_en.
  - A reset mid-sequence abandons the sequence with no done pulse.
- sample_en=0: state, mode, err and seq_count hold; done=0.
- Pattern P={left,right}. On each sample_en=1 edge:
  - IDLE:
    - P=000/000 -> IDLE.
    - left=001, right=000 -> L1.
    - left=000, right=001 -> R1.
    - P=111/111 -> HAZ.
    - Anything else -> ERR.
  - L1: left=011, right=000 -> L2; else -> ERR.
  - L2: left=111, right=000 -> L3; else -> ERR.
  - L3: P=000/000 -> IDLE and complete(left); else -> ERR.
  - R1/R2/R3: mirror of L1-L3 on right, with left=000; completion gives complete(right).
  - HAZ: P=000/000 -> IDLE and complete(hazard); else -> ERR.
  - ERR:
    - P=000/000 -> IDLE; otherwise stay in ERR.
    - No completion is reported from ERR or from the IDLE state it returns to.
- Entering ERR sets err=1, visible the cycle after the offending sample edge. err stays 1 until reset, including after ERR recovers to IDLE.
- complete(x), registered on the same edge as the transition:
  - mode<=x.
  - done<=1 for exactly one cycle.
  - seq_count<=seq_count+1; holds at 2^CNT_W-1 once reached, with no wrap.
  - Latency: done is high in the cycle immediately after the edge that sampled the final all-off pattern.
- mode holds its last value between completions. It is not cleared by err or by entering ERR.
- Back-to-back sequences are legal. The completing all-off sample already puts the FSM in IDLE, so the next sample may be the next sequence's first pattern (e.g. left=001).
- Non-contiguous sample_en (gaps of sample_en=0 between samples) has no effect on decoding.
- Left and right bits must never both be nonzero except in the hazard all-on pattern. Any such overlap is an error.

Test Plan:
- Reset low 2 cycles, then samples L: 001/000, 011/000, 111/000, 000/000 -> done pulses once, one cycle after the 4th sample; mode=01, seq_count=1, err=0.
- Right sequence 000/001, 000/011, 000/111, 000/000, then immediately hazard 111/111, 000/000 -> done pulses twice; mode=10 then 11; seq_count=2.
- Left sequence with sample_en=0 for 3 cycles between each sample, lamp inputs driven to garbage (101/110) while sample_en=0 -> identical result to test 1, err=0.
- Illegal sample 011/000 from IDLE -> err=1 the next cycle; then 111/000 (ERR holds); then 000/000 (IDLE); then a full left sequence -> done, mode=01, err stays 1.
- Left 001/000, 011/000, then reset=0 for 1 cycle, then 111/000 -> all outputs 0 after reset; the 111/000 sample sets err=1; no done pulse.
- CNT_W=2: five back-to-back hazard sequences -> seq_count 1,2,3,3,3 and done pulses 5 times.
